// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage issue controller for the HI/LO mult/div unit.
// Turns the E-stage md-op into start/op/A/B for the unit, keeps a
// cycle-exact mirror of the unit's busy window so the D-stage stall can
// rise in the issue cycle itself, and flags any disagreement with the unit.
module md_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_mdop,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic [3:0]  d_mdop,
  input  logic        req,
  input  logic        md_busy,
  output logic        md_start,
  output logic [3:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        stall,
  output logic        run,
  output logic        proto_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_MULTU = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;

  logic [0:0]       state_reg;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             proto_err_reg;

  logic             e_is_md;
  logic             e_is_start;
  logic             d_is_md;
  logic             issue;
  logic [CNT_W-1:0] e_lat;

  // Decode the E- and D-stage ops and form the issue condition.
  always_comb begin
    e_is_md    = (e_mdop >= 4'd1) && (e_mdop <= 4'd8);
    d_is_md    = (d_mdop >= 4'd1) && (d_mdop <= 4'd8);
    e_is_start = (e_mdop == OP_MULT) || (e_mdop == OP_DIV) ||
                 (e_mdop == OP_MULTU) || (e_mdop == OP_DIVU);
    e_lat      = ((e_mdop == OP_MULT) || (e_mdop == OP_MULTU)) ?
                 CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
    issue      = e_valid && e_is_start && !req && (state_reg == IDLE);
  end

  // Outputs to the unit and to the pipeline. The stall includes the issue
  // term so it rises in the same cycle the op is launched.
  always_comb begin
    run       = (state_reg == RUN);
    md_start  = issue;
    md_op     = (e_valid && !req) ? e_mdop : 4'd0;
    md_a      = e_rs;
    md_b      = e_rt;
    stall     = d_is_md && (run || issue);
    proto_err = proto_err_reg;
  end

  // Next-state logic for the busy mirror: RUN lasts exactly the op latency.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (issue) begin
          cnt_next   = e_lat;
          state_next = RUN;
        end
      end
      default: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // Mirror state registers; a reset mid-run abandons the mirror at once,
  // matching the unit which shares the same reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Sticky protocol error: unit busy disagrees with the mirror, or an md op
  // reached E while the unit was still busy (the stall was bypassed).
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err_reg <= 1'b0;
    end else if ((md_busy != run) || (e_valid && e_is_md && run)) begin
      proto_err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Testbench for md_issue_ctrl: a behavioural mult/div unit answers the
// controller, and a cycle-numbered reference model predicts every output.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_mdop;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic [3:0]  d_mdop;
  logic        req;
  logic        md_busy;
  logic        md_start;
  logic [3:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        stall;
  logic        run;
  logic        proto_err;

  always #5 clk = ~clk;

  md_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_mdop(e_mdop),
    .e_rs(e_rs), .e_rt(e_rt), .d_mdop(d_mdop), .req(req),
    .md_busy(md_busy), .md_start(md_start), .md_op(md_op),
    .md_a(md_a), .md_b(md_b), .stall(stall), .run(run),
    .proto_err(proto_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the mirror is busy for cycles (issue_cycle, busy_last].
  int cyc       = 0;
  int busy_last = -1;
  bit proto_m   = 1'b0;

  // Behavioural mult/div unit driven by the DUT outputs.
  int          ucnt = 0;
  logic [31:0] hi   = '0;
  logic [31:0] lo   = '0;

  // Values observed in the most recent step, for directed checks.
  logic       obs_start, obs_run, obs_stall, obs_proto;
  logic [3:0] obs_op;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit is_md(input logic [3:0] x);
    return (x >= 4'd1) && (x <= 4'd8);
  endfunction

  function automatic bit is_start(input logic [3:0] x);
    return (x == 4'd1) || (x == 4'd2) || (x == 4'd7) || (x == 4'd8);
  endfunction

  function automatic int lat(input logic [3:0] x);
    return ((x == 4'd1) || (x == 4'd7)) ? 5 : 10;
  endfunction

  // Unit arithmetic: mult/multu -> {HI,LO}; div/divu -> LO=quotient, HI=remainder.
  task automatic unit_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    case (op)
      4'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); hi = sp[63:32]; lo = sp[31:0]; end
      4'd7: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); hi = up[63:32]; lo = up[31:0]; end
      4'd2: if (b != 0 && !(a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
              lo = $signed(a) / $signed(b);
              hi = $signed(a) % $signed(b);
            end
      4'd8: if (b != 0) begin lo = a / b; hi = a % b; end
      default: ;
    endcase
  endtask

  // One clock cycle: drive after the falling edge, check just after, update
  // both models at the rising edge.
  task automatic step(input bit v, input logic [3:0] eop, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [3:0] dop, input bit rq,
                      input bit rst, input bit flip);
    bit         run_e, iss_e, bsy, s;
    logic [3:0] op_e, o;
    @(negedge clk);
    e_valid = v;  e_mdop = eop; e_rs = rs; e_rt = rt;
    d_mdop  = dop; req = rq; reset = rst;
    bsy     = (ucnt != 0) ^ flip;
    md_busy = bsy;
    #1;
    run_e = (cyc <= busy_last);
    iss_e = v && is_start(eop) && !rq && !run_e;
    op_e  = (v && !rq) ? eop : 4'd0;
    check("run",   32'(run),       32'(run_e));
    check("start", 32'(md_start),  32'(iss_e));
    check("op",    32'(md_op),     32'(op_e));
    check("a",     md_a,           rs);
    check("b",     md_b,           rt);
    check("stall", 32'(stall),     32'(is_md(dop) && (run_e || iss_e)));
    check("proto", 32'(proto_err), 32'(proto_m));
    obs_start = md_start; obs_run = run; obs_stall = stall;
    obs_proto = proto_err; obs_op = md_op;
    s = md_start; o = md_op;
    @(posedge clk);
    if (rst) begin
      busy_last = -1; proto_m = 1'b0;
      ucnt = 0; hi = '0; lo = '0;
    end else begin
      if (iss_e) busy_last = cyc + lat(eop);
      if ((bsy != run_e) || (v && is_md(eop) && run_e)) proto_m = 1'b1;
      if (ucnt != 0) ucnt--;
      else if (s) begin unit_compute(o, rs, rt); ucnt = lat(o); end
      else if (o == 4'd3) hi = rs;
      else if (o == 4'd4) lo = rs;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic [3:0] dop);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0, dop, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  // Random cycles; when legal_only, no md op is put into E while the model is busy.
  task automatic random_phase(input int n, input bit legal_only);
    bit          v, rq, fl;
    logic [3:0]  eop, dop;
    logic [31:0] rs, rt;
    for (int i = 0; i < n; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      rq  = ($urandom_range(0, 9) == 0);
      dop = 4'($urandom_range(0, 8));
      eop = 4'($urandom_range(0, 8));
      rs  = $urandom;
      rt  = $urandom;
      if (rt == 0) rt = 32'd1;
      fl  = !legal_only && ($urandom_range(0, 19) == 0);
      if (legal_only && (cyc <= busy_last)) eop = 4'd0;
      step(v, eop, rs, rt, dop, rq, 1'b0, fl);
    end
  endtask

  logic [31:0] lo_save;

  initial begin
    do_reset();
    check("rst_run",   32'(obs_run),   32'd0);
    check("rst_proto", 32'(obs_proto), 32'd0);

    // mult 7 * -3
    step(1'b1, 4'd1, 32'd7, 32'hFFFF_FFFD, 4'd0, 1'b0, 1'b0, 1'b0);
    check("t1_start", 32'(obs_start), 32'd1);
    idle(6, 4'd0);
    check("t1_hi", hi, 32'hFFFF_FFFF);
    check("t1_lo", lo, 32'hFFFF_FFEB);
    check("t1_proto", 32'(obs_proto), 32'd0);

    // div 100 / 7 with mflo waiting in D
    step(1'b1, 4'd2, 32'd100, 32'd7, 4'd6, 1'b0, 1'b0, 1'b0);
    check("t2_stall0", 32'(obs_stall), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 4'd0, 32'd0, 32'd0, 4'd6, 1'b0, 1'b0, 1'b0);
      check("t2_stall", 32'(obs_stall), 32'd1);
    end
    step(1'b1, 4'd6, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("t2_run", 32'(obs_run), 32'd0);
    check("t2_lo", lo, 32'd14);
    check("t2_hi", hi, 32'd2);

    // divu with req mid-run, then back-to-back multu
    step(1'b1, 4'd8, 32'd50, 32'd5, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++)
      step(1'b0, 4'd0, 32'd0, 32'd0, 4'd5, (i == 3), 1'b0, 1'b0);
    check("t3_run_last", 32'(obs_run), 32'd1);
    step(1'b1, 4'd7, 32'd3, 32'd4, 4'd0, 1'b0, 1'b0, 1'b0);
    check("t3_run_end", 32'(obs_run), 32'd0);
    check("t3_start", 32'(obs_start), 32'd1);
    idle(6, 4'd0);
    check("t3_lo", lo, 32'd12);

    // req suppresses mult issue and mtlo write
    step(1'b1, 4'd1, 32'd5, 32'd5, 4'd0, 1'b1, 1'b0, 1'b0);
    check("t4_start", 32'(obs_start), 32'd0);
    check("t4_op", 32'(obs_op), 32'd0);
    lo_save = lo;
    step(1'b1, 4'd4, 32'h1234, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(1, 4'd0);
    check("t4_run", 32'(obs_run), 32'd0);
    check("t4_lo", lo, lo_save);

    // reset during a div run
    step(1'b1, 4'd2, 32'd9, 32'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 32'd0, 32'd0, 4'd6, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 32'd0, 32'd0, 4'd6, 1'b0, 1'b0, 1'b0);
    check("t5_run", 32'(obs_run), 32'd0);
    check("t5_stall", 32'(obs_stall), 32'd0);
    check("t5_proto", 32'(obs_proto), 32'd0);
    check("t5_busy", 32'(md_busy), 32'd0);

    // busy forced low during RUN
    step(1'b1, 4'd1, 32'd2, 32'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(6, 4'd0);
    check("t6a_proto", 32'(obs_proto), 32'd1);
    do_reset();
    check("t6a_clear", 32'(obs_proto), 32'd0);

    // div injected into E while busy
    step(1'b1, 4'd1, 32'd2, 32'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd2, 32'd8, 32'd2, 4'd0, 1'b0, 1'b0, 1'b0);
    check("t6b_start", 32'(obs_start), 32'd0);
    check("t6b_op", 32'(obs_op), 32'd2);
    idle(6, 4'd0);
    check("t6b_proto", 32'(obs_proto), 32'd1);
    do_reset();

    // randomized legal traffic, then unrestricted traffic with busy faults
    random_phase(500, 1'b1);
    do_reset();
    random_phase(300, 1'b0);
    do_reset();
    random_phase(300, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
